// File: rtl/conv_vect_feeder.sv
// Input buffer and sample repeater ahead of the serial-vector convolution stage:
// each buffered sample is held for REPEAT valid cycles, with an idle gap after every line end.
module conv_vect_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int REPEAT     = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int GAP_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_i,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic                         sop_i,
  input  logic                         eop_i,
  input  logic                         sof_i,
  input  logic                         eof_i,
  output logic                         ready_o,
  output logic                         overflow_o,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         valid_o,
  output logic                         sop_o,
  output logic                         eop_o,
  output logic                         sof_o,
  output logic                         eof_o
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int RW     = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam int GW     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int EW     = DATA_WIDTH + 4;
  localparam bit GAP_EN = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [EW-1:0] rd_entry;
  logic          push, pop, fifo_ne, rep_last, gap_last;

  state_t        state;
  logic [RW-1:0] rep_cnt;
  logic [GW-1:0] gap_cnt;
  logic          h_eop, h_eof;

  // entry layout: {sop, eop, sof, eof, data}
  assign rd_entry = mem[rd_ptr];
  assign ready_o  = (count != CW'(FIFO_DEPTH));
  assign fifo_ne  = (count != '0);
  assign push     = valid_i & ready_o;
  assign rep_last = (rep_cnt == RW'(REPEAT - 1));
  assign gap_last = (gap_cnt == GW'(GAP_CYCLES - 1));

  // Pop exactly when the repeater is about to need a new entry, so back-to-back entries have no bubble.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = fifo_ne;
      EMIT:    pop = fifo_ne & rep_last & ~(h_eop & GAP_EN);
      GAP:     pop = fifo_ne & gap_last;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sop_i, eop_i, sof_i, eof_i, data_i};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (valid_i && !ready_o) overflow_o <= 1'b1;
    end
  end

  // Repeater FSM; all outputs are registered here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rep_cnt <= '0;
      gap_cnt <= '0;
      h_eop   <= 1'b0;
      h_eof   <= 1'b0;
      data_o  <= '0;
      valid_o <= 1'b0;
      sop_o   <= 1'b0;
      eop_o   <= 1'b0;
      sof_o   <= 1'b0;
      eof_o   <= 1'b0;
    end else if (pop) begin
      state   <= EMIT;
      rep_cnt <= '0;
      data_o  <= rd_entry[DATA_WIDTH-1:0];
      h_eop   <= rd_entry[EW-2];
      h_eof   <= rd_entry[EW-4];
      valid_o <= 1'b1;
      sop_o   <= rd_entry[EW-1];
      sof_o   <= rd_entry[EW-3];
      eop_o   <= (REPEAT == 1) && rd_entry[EW-2];
      eof_o   <= (REPEAT == 1) && rd_entry[EW-4];
    end else begin
      case (state)
        EMIT: begin
          if (rep_last) begin
            valid_o <= 1'b0;
            sop_o   <= 1'b0;
            eop_o   <= 1'b0;
            sof_o   <= 1'b0;
            eof_o   <= 1'b0;
            if (h_eop && GAP_EN) begin
              state   <= GAP;
              gap_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            // end-of flags go out on the final repeat cycle of the entry
            rep_cnt <= rep_cnt + RW'(1);
            sop_o   <= 1'b0;
            sof_o   <= 1'b0;
            eop_o   <= h_eop && (rep_cnt == RW'(REPEAT - 2));
            eof_o   <= h_eof && (rep_cnt == RW'(REPEAT - 2));
          end
        end
        GAP: begin
          if (gap_last) state <= IDLE;
          else          gap_cnt <= gap_cnt + GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_vect_feeder.md
# conv_vect_feeder

Source-side companion to the serial-vector convolution stage. Accepts the pixel stream of input-channel samples (framed with sop/eop/sof/eof), buffers it, and re-emits every sample held for REPEAT consecutive valid cycles, one per output channel, so the downstream multiply–accumulate can walk its kernel ROM. After each line it inserts a programmable idle gap so the downstream pipeline drains between lines. Sits directly upstream of the convolution stage in every 1×1 conv layer.

## Interface
- DATA_WIDTH, 8, signed sample width
- REPEAT, 16, output cycles per sample (= downstream CHANNEL_NUM); ≥1
- FIFO_DEPTH, 64, input buffer entries; power of 2, ≥4
- GAP_CYCLES, 4, idle cycles forced after an eop entry; 0 = none
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- valid_i  in  1  input sample strobe
- data_i  in  DATA_WIDTH  signed input sample
- sop_i / eop_i / sof_i / eof_i  in  1 each  framing flags, meaningful only with valid_i
- ready_o  in→out  1  high when buffer can accept a sample
- overflow_o  out  1  sticky: valid_i seen while ready_o low
- data_o  out  DATA_WIDTH  held sample
- valid_o  out  1  output strobe
- sop_o / eop_o / sof_o / eof_o  out  1 each  output framing flags

## Operation
- Buffer: synchronous FIFO of {data, sop, eop, sof, eof}; count register of $clog2(FIFO_DEPTH)+1 bits. Push = valid_i & ready_o. ready_o = (count != FIFO_DEPTH), combinational from count. Push and pop in same cycle: count unchanged. valid_i while full: sample dropped, overflow_o set until reset.
- FSM states: IDLE, EMIT, GAP.
  - IDLE: if FIFO non-empty → pop, load holding register, rep_cnt←0, go EMIT.
  - EMIT: valid_o high every cycle; rep_cnt increments 0..REPEAT-1. On rep_cnt==REPEAT-1: if held entry has eop and GAP_CYCLES>0 → GAP (gap_cnt←0); else if FIFO non-empty → pop next, rep_cnt←0, stay EMIT (no bubble); else → IDLE.
  - GAP: valid_o low; after GAP_CYCLES cycles → IDLE (or directly pop into EMIT if non-empty, no extra bubble).
- Flags per held entry: sop_o and sof_o asserted only on rep_cnt==0 cycle; eop_o and eof_o only on rep_cnt==REPEAT-1 cycle; all flags low whenever valid_o low. REPEAT=1: all flags of an entry appear on its single cycle.
- data_o constant across all REPEAT cycles of an entry; holds last value when idle.
- No arithmetic on data; width preserved, sign irrelevant to block.
- Reset mid-operation: FIFO emptied, FSM→IDLE, counters cleared, partially emitted entry discarded.

## Timing
- Reset values: valid_o, sop_o, eop_o, sof_o, eof_o, overflow_o = 0; data_o = 0; ready_o = 1 (count=0).
- All outputs except ready_o are registered.
- Latency: sample pushed at edge N into empty FIFO, FSM in IDLE → first valid_o cycle is N+2.
- Throughput: one sample per REPEAT cycles, continuous when FIFO non-empty and no eop gap.
- Gap: last eop cycle at M → next valid_o no earlier than M+GAP_CYCLES+1.
- ready_o falls in the cycle after the push that makes count==FIFO_DEPTH; rises the cycle after the pop that frees an entry.

## Test plan
- Single sample: REPEAT=4, push data 0x05 with sop,eop,sof,eof at cycle 10 → valid_o cycles 12–15, data_o=0x05; sop_o/sof_o at 12 only; eop_o/eof_o at 15 only; GAP_CYCLES=4 → valid_o low 16–19.
- Line streaming: REPEAT=3, 8 samples −4..3 back-to-back, sop first, eop last → 24 contiguous valid_o cycles, each value 3 times, one sop_o at first and one eop_o at last output cycle.
- Backpressure: FIFO_DEPTH=4, REPEAT=16, push 6 samples continuously → ready_o low after 5th push accepted (one in holding reg, 4 buffered); sender stalls; all 6 emitted in order, overflow_o stays 0.
- Overflow: with ready_o low, drive valid_i with 0x7F → sample never appears on data_o, overflow_o=1 until reset.
- REPEAT=1 pass-through: random 100 samples with framing → output sequence identical to input, flags aligned per sample.
- Reset mid-emit: assert reset at rep_cnt=2 of a held entry with 3 buffered → all outputs 0, ready_o=1 next cycle; after release, new sample emitted normally, no stale data.
